// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and register-ref definitions for the sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_INDIRECT = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_BUN = 3'b100;
  localparam logic [2:0] OP_ISZ = 3'b110;
  localparam logic [2:0] OP_REG = 3'b111;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_HLT = 0;

  typedef struct packed {
    logic clr_ac;
    logic clr_e;
    logic comp_ac;
    logic load_ac;
    logic cir_r;
    logic cir_l;
    logic inc_ac;
    logic add;
    logic load;
    logic store;
    logic branch;
    logic isz;
  } strobe_t;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - memory, datapath and phase-strobe signals of the sequencer
interface control_unit_if #(
  parameter int DWIDTH = 16
);
  logic              i_start;
  logic [DWIDTH-1:0] i_mem_data;
  logic              i_mem_valid;
  logic              i_ex_done;
  logic              o_read;
  logic [DWIDTH-1:0] o_ir;
  logic              o_fetch;
  logic              o_execute;
  logic              o_is_ind;
  logic              o_is_dir;
  logic              o_clr_ac;
  logic              o_clr_e;
  logic              o_comp_ac;
  logic              o_load_ac;
  logic              o_cir_r;
  logic              o_cir_l;
  logic              o_inc_ac;
  logic              o_add;
  logic              o_load;
  logic              o_store;
  logic              o_branch;
  logic              o_isz;
  logic              o_halted;
  logic              o_error;

  modport master (
    input  i_start, i_mem_data, i_mem_valid, i_ex_done,
    output o_read, o_ir, o_fetch, o_execute, o_is_ind, o_is_dir,
           o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
           o_add, o_load, o_store, o_branch, o_isz, o_halted, o_error
  );

  modport slave (
    output i_start, i_mem_data, i_mem_valid, i_ex_done,
    input  o_read, o_ir, o_fetch, o_execute, o_is_ind, o_is_dir,
           o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
           o_add, o_load, o_store, o_branch, o_isz, o_halted, o_error
  );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// rtl/control_unit_instr_decoder.sv - combinational IR decode into one-hot strobes and class flags
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH-1:0] ir,
  output strobe_t           strobe,
  output logic              is_mem,
  output logic              is_ind,
  output logic              is_halt,
  output logic              is_nop
);

  logic [2:0] op;
  logic       i_bit;
  logic       unused_ir_bits;

  assign op    = ir[14:12];
  assign i_bit = ir[15];
  assign unused_ir_bits = ^{ir[8], ir[4:1]};

  always_comb begin
    strobe  = '0;
    is_mem  = 1'b0;
    is_ind  = 1'b0;
    is_halt = 1'b0;
    is_nop  = 1'b0;
    case (op)
      OP_REG: begin
        // Only the highest-priority register-ref bit is issued; no bit set is an EXEC-phase NOP
        if (i_bit)                strobe.load_ac = 1'b1;
        else if (ir[RR_HLT])      is_halt        = 1'b1;
        else if (ir[RR_CLA])      strobe.clr_ac  = 1'b1;
        else if (ir[RR_CLE])      strobe.clr_e   = 1'b1;
        else if (ir[RR_CMA])      strobe.comp_ac = 1'b1;
        else if (ir[RR_CIR])      strobe.cir_r   = 1'b1;
        else if (ir[RR_CIL])      strobe.cir_l   = 1'b1;
        else if (ir[RR_INC])      strobe.inc_ac  = 1'b1;
      end
      OP_ADD: begin is_mem = 1'b1; is_ind = i_bit; strobe.add    = 1'b1; end
      OP_LDA: begin is_mem = 1'b1; is_ind = i_bit; strobe.load   = 1'b1; end
      OP_STA: begin is_mem = 1'b1; is_ind = i_bit; strobe.store  = 1'b1; end
      OP_BUN: begin is_mem = 1'b1; is_ind = i_bit; strobe.branch = 1'b1; end
      OP_ISZ: begin is_mem = 1'b1; is_ind = i_bit; strobe.isz    = 1'b1; end
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/indirect/execute sequencer driving the accumulator datapath
module control_unit
  import cpu_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 12,
  parameter int TO_W         = 4,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           i_clr_reg,
  control_unit_if.master bus
);

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              error_q, error_d;

  strobe_t dec_strobe;
  logic    dec_is_mem;
  logic    dec_is_ind;
  logic    dec_is_halt;
  logic    dec_is_nop;

  instr_decoder #(.DWIDTH(DWIDTH)) u_dec (
    .ir      (ir_q),
    .strobe  (dec_strobe),
    .is_mem  (dec_is_mem),
    .is_ind  (dec_is_ind),
    .is_halt (dec_is_halt),
    .is_nop  (dec_is_nop)
  );

  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    error_d = error_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.i_start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.i_mem_valid) begin
          ir_d    = bus.i_mem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_is_nop)       state_d = ST_FETCH;
        else if (dec_is_halt) state_d = ST_HALT;
        else if (dec_is_ind)  state_d = ST_INDIRECT;
        else                  state_d = ST_EXEC;
      end
      ST_INDIRECT: begin
        if (bus.i_mem_valid) begin
          ir_d[AWIDTH-1:0] = bus.i_mem_data[AWIDTH-1:0];
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.i_ex_done) begin
          state_d = ST_FETCH;
        end else begin
          // Saturating count: the EXEC_TIMEOUT-th cycle without done ends the instruction
          cnt_d = (cnt_q != '1) ? cnt_q + TO_W'(1) : cnt_q;
          if (cnt_d >= TO_W'(EXEC_TIMEOUT)) begin
            state_d = ST_HALT;
            error_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic in_exec;
  assign in_exec = (state_q == ST_EXEC);

  assign bus.o_read    = (state_q == ST_FETCH) || (state_q == ST_INDIRECT);
  assign bus.o_fetch   = (state_q == ST_FETCH);
  assign bus.o_is_ind  = (state_q == ST_INDIRECT);
  assign bus.o_execute = in_exec;
  assign bus.o_is_dir  = in_exec && dec_is_mem;
  assign bus.o_halted  = (state_q == ST_HALT);
  assign bus.o_error   = error_q;
  assign bus.o_ir      = ir_q;

  assign bus.o_clr_ac  = in_exec && dec_strobe.clr_ac;
  assign bus.o_clr_e   = in_exec && dec_strobe.clr_e;
  assign bus.o_comp_ac = in_exec && dec_strobe.comp_ac;
  assign bus.o_load_ac = in_exec && dec_strobe.load_ac;
  assign bus.o_cir_r   = in_exec && dec_strobe.cir_r;
  assign bus.o_cir_l   = in_exec && dec_strobe.cir_l;
  assign bus.o_inc_ac  = in_exec && dec_strobe.inc_ac;
  assign bus.o_add     = in_exec && dec_strobe.add;
  assign bus.o_load    = in_exec && dec_strobe.load;
  assign bus.o_store   = in_exec && dec_strobe.store;
  assign bus.o_branch  = in_exec && dec_strobe.branch;
  assign bus.o_isz     = in_exec && dec_strobe.isz;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed-vector bench for control_unit
module tb_control_unit;

  logic clk;
  logic i_clr_reg;
  int   n_vec;
  int   n_bad;

  control_unit_if #(.DWIDTH(16)) bus ();

  control_unit #(
    .DWIDTH(16), .AWIDTH(12), .TO_W(4), .EXEC_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .i_clr_reg (i_clr_reg),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe word: {fetch, execute, is_ind, is_dir, clr_ac, clr_e, comp_ac, load_ac,
  //               cir_r, cir_l, inc_ac, add, load, store, branch, isz}
  logic [15:0] strb;
  assign strb = {bus.o_fetch, bus.o_execute, bus.o_is_ind, bus.o_is_dir,
                 bus.o_clr_ac, bus.o_clr_e, bus.o_comp_ac, bus.o_load_ac,
                 bus.o_cir_r, bus.o_cir_l, bus.o_inc_ac,
                 bus.o_add, bus.o_load, bus.o_store, bus.o_branch, bus.o_isz};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] data);
    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = data;
    tick();
    bus.i_mem_valid = 1'b0;
    bus.i_mem_data  = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    i_clr_reg       = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_mem_data  = 16'h0000;
    bus.i_mem_valid = 1'b0;
    bus.i_ex_done   = 1'b0;
    tick();
    tick();
    chk("rst_strb",  32'(strb), 32'h0000);
    chk("rst_read",  32'(bus.o_read), 32'd0);
    chk("rst_ir",    32'(bus.o_ir), 32'h0000);
    chk("rst_halt",  32'(bus.o_halted), 32'd0);
    chk("rst_err",   32'(bus.o_error), 32'd0);
    i_clr_reg = 1'b0;
    tick();
    chk("idle_strb", 32'(strb), 32'h0000);

    // LDA direct 0x123
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("f1_read", 32'(bus.o_read), 32'd1);
    chk("f1_strb", 32'(strb), 32'h8000);
    tick();
    chk("f1_wait", 32'(strb), 32'h8000);
    feed(16'h2123);
    chk("d1_strb", 32'(strb), 32'h0000);
    chk("d1_ir",   32'(bus.o_ir), 32'h2123);
    tick();
    chk("e1_strb", 32'(strb), 32'h5008);
    bus.i_ex_done = 1'b1;
    tick();
    bus.i_ex_done = 1'b0;
    chk("f2_strb", 32'(strb), 32'h8000);
    chk("f2_read", 32'(bus.o_read), 32'd1);

    // STA indirect, pointer word 0x0ABC
    feed(16'hB050);
    chk("d2_ir", 32'(bus.o_ir), 32'hB050);
    tick();
    chk("i2_strb", 32'(strb), 32'h2000);
    chk("i2_read", 32'(bus.o_read), 32'd1);
    feed(16'h0ABC);
    chk("e2_strb", 32'(strb), 32'h5004);
    chk("e2_ir",   32'(bus.o_ir), 32'hBABC);
    bus.i_ex_done = 1'b1;
    tick();
    bus.i_ex_done = 1'b0;

    // CLA+CMA+INC: only CLA issued, held while done is low
    feed(16'h7A20);
    tick();
    chk("e3_strb",  32'(strb), 32'h4800);
    tick();
    chk("e3_hold",  32'(strb), 32'h4800);
    bus.i_ex_done = 1'b1;
    tick();
    bus.i_ex_done = 1'b0;
    chk("f4_strb",  32'(strb), 32'h8000);

    // HLT
    feed(16'h7001);
    tick();
    chk("h4_halt", 32'(bus.o_halted), 32'd1);
    chk("h4_strb", 32'(strb), 32'h0000);
    chk("h4_read", 32'(bus.o_read), 32'd0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("h4_refetch", 32'(bus.o_read), 32'd1);
    chk("h4_unhalt",  32'(bus.o_halted), 32'd0);

    // ADD direct with no done: timeout after 15 EXEC cycles
    feed(16'h1010);
    tick();
    chk("e5_strb", 32'(strb), 32'h5010);
    for (int i = 0; i < 14; i++) tick();
    chk("e5_last_exec", 32'(bus.o_execute), 32'd1);
    chk("e5_no_err_yet", 32'(bus.o_error), 32'd0);
    tick();
    chk("e5_err",  32'(bus.o_error), 32'd1);
    chk("e5_halt", 32'(bus.o_halted), 32'd1);
    chk("e5_strb_halt", 32'(strb), 32'h0000);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("e5_err_sticky", 32'(bus.o_error), 32'd1);
    chk("e5_refetch",    32'(bus.o_read), 32'd1);

    // Reset while in INDIRECT, then a reserved-op NOP
    feed(16'h9123);
    tick();
    chk("i6_strb", 32'(strb), 32'h2000);
    #2;
    i_clr_reg = 1'b1;
    #1;
    chk("r6_strb", 32'(strb), 32'h0000);
    chk("r6_read", 32'(bus.o_read), 32'd0);
    chk("r6_ir",   32'(bus.o_ir), 32'h0000);
    chk("r6_err",  32'(bus.o_error), 32'd0);
    tick();
    i_clr_reg = 1'b0;
    tick();
    chk("r6_idle", 32'(strb), 32'h0000);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    feed(16'h0000);
    chk("n6_decode", 32'(strb), 32'h0000);
    tick();
    chk("n6_fetch", 32'(strb), 32'h8000);
    chk("n6_read",  32'(bus.o_read), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer that sits directly upstream of the accumulator datapath.
- Fetches the instruction word from memory, latches it in IR, and decodes opcode, I bit and register-reference bits.
- Resolves indirect addressing.
- Drives one-hot execute strobes into the datapath, then waits for the datapath's done flag before fetching the next instruction.

Parameters:
- DWIDTH, 16, instruction/data word width
- AWIDTH, 12, address field width (IR[AWIDTH-1:0])
- TO_W, 4, timeout counter width
- EXEC_TIMEOUT, 15, maximum cycles in EXEC waiting for i_ex_done

Ports:
- clk  in  1  clock, rising edge
- i_clr_reg  in  1  reset, asynchronous, active-high
- i_start  in  1  leave IDLE/HALT, begin fetching
- i_mem_data  in  16  memory read data
- i_mem_valid  in  1  i_mem_data valid for the current o_read
- i_ex_done  in  1  datapath finished the current instruction
- o_read  out  1  memory read request
- o_ir  out  16  latched instruction; [11:0] replaced by the effective address after indirect
- o_fetch, o_execute, o_is_ind, o_is_dir  out  1 each  phase strobes
- o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  out  1 each  register-ref strobes
- o_add, o_load, o_store, o_branch, o_isz  out  1 each  memory-ref strobes
- o_halted  out  1  in HALT state
- o_error  out  1  sticky flag, set on execute timeout

Behaviour:
- Reset: state=IDLE, IR=0, timeout counter=0, all outputs 0.
- States:
  - IDLE: waits for i_start.
  - FETCH: o_read=o_fetch=1. On i_mem_valid, IR<=i_mem_data and go to DECODE. Otherwise stay (no timeout).
  - DECODE: 1 cycle, no strobes.
    - op=IR[14:12], I=IR[15].
    - op=111 & I=0: register-ref → EXEC.
    - op=111 & I=1: LDI (o_load_ac) → EXEC.
    - op in {001 ADD, 010 LDA, 011 STA, 100 BUN, 110 ISZ}: → INDIRECT if I=1, else EXEC.
    - op in {000, 101}: reserved NOP → FETCH, no strobe.
    - Register-ref with IR[0]=1 (HLT): → HALT.
  - INDIRECT: o_read=o_is_ind=1. On i_mem_valid, IR[11:0]<=i_mem_data[11:0] and go to EXEC.
  - EXEC:
    - o_execute=1 for every op.
    - o_is_dir=1 for memory-ref ops.
    - Exactly one op strobe is held for the whole stay in EXEC.
    - Register-ref priority when several bits are set: bit11 CLA > bit10 CLE > bit9 CMA > bit7 CIR > bit6 CIL > bit5 INC. Only the highest-priority set bit is issued. Other bits are ignored. No bits set = NOP, but i_ex_done is still awaited.
    - i_ex_done=1: → FETCH next cycle, counter cleared.
    - Counter reaches EXEC_TIMEOUT with no done: o_error<=1, → HALT.
  - HALT: o_halted=1, no strobes. i_start → FETCH; o_error stays set until reset.
- All outputs are registered or decoded from registered state; no combinational path from inputs to strobes.
- Strobes change only on state transitions.
- Minimum latency: direct memory-ref = FETCH(1) + DECODE(1) + EXEC(1) = 3 cycles with immediate valid/done. Indirect adds ≥1 cycle.
- i_mem_valid outside FETCH/INDIRECT is ignored.
- i_ex_done outside EXEC is ignored.
- i_start outside IDLE/HALT is ignored.
- i_start and i_ex_done in the same cycle: no interaction.
- Reset mid-instruction: immediate return to IDLE, strobes drop asynchronously.
- Timeout counter saturates; it does not wrap.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (IDLE, FETCH, DECODE, INDIRECT, EXEC, HALT)
  - opcode constants (OP_ADD=3'b001, OP_LDA=3'b010, OP_STA=3'b011, OP_BUN=3'b100, OP_ISZ=3'b110, OP_REG=3'b111)
  - register-ref bit indices (RR_CLA=11, RR_CLE=10, RR_CMA=9, RR_CIR=7, RR_CIL=6, RR_INC=5, RR_HLT=0)
- One sub-module: instr_decoder, purely combinational. Maps IR to a strobe vector plus is_mem/is_ind/is_halt/is_nop flags.

Test Plan:
- Reset, i_start, memory returns 16'h2123 (LDA direct, 0x123) with 1-cycle valid, i_ex_done 1 cycle later → o_read in FETCH; o_is_dir=o_load=o_execute=1 for one cycle; o_ir=16'h2123; back in FETCH.
- 16'hB050 (STA indirect), indirect fetch returns 16'h0ABC → o_is_ind pulse with o_read; then o_store=1 with o_ir[11:0]=12'hABC.
- 16'h7A20 (CLA+CMA+INC set) → only o_clr_ac asserted in EXEC; no other register-ref strobe.
- 16'h7001 (HLT) → o_halted=1, no strobes; i_start pulse → FETCH with o_read=1.
- 16'h1010 (ADD), i_ex_done held 0 → after EXEC_TIMEOUT=15 cycles o_error=1 and o_halted=1; o_error stays 1 after i_start.
- i_clr_reg asserted mid-INDIRECT → all outputs 0 immediately, state IDLE; 16'h0000 fetched after restart → NOP, returns to FETCH without o_execute.
